// File: rtl/sfu_acc_bank.sv
// sfu_acc_bank: special function unit sitting between OFIFO and PMEM.
// Each of `col` lanes owns a bank of `depth` signed accumulators addressed by
// output pixel. A bypass path forwards raw PSUMs one beat at a time. A flush
// post-processes every entry (activation, requant shift, saturation), drains
// the bank in address order through a valid/ready port and clears it.
//
// Ports
//   clk, reset       clock (rising edge), async active-low reset
//   mode             0 bypass / 1 accumulate, sampled per input handshake
//   act_sel          00 none, 01 ReLU, 10 leaky, 11 none
//   leak_shift       leaky negative-slope arithmetic right shift
//   out_shift        requant arithmetic right shift
//   in_valid/ready   input handshake for in_addr, in_first, psum_in
//   in_addr          accumulator entry, in_first overwrites instead of adding
//   psum_in          lane i at psum_in[psum_bw*i +: psum_bw]
//   flush_start      one-cycle drain request
//   out_valid/ready  output handshake for out_addr, sfp_out
//   sfp_out          lane i at slot col-1-i
//   busy, done       flush in progress / one-cycle completion pulse
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_RUN   | normal operation: bypass or accumulate, accepts flush request
// S_FLUSH | draining entries 0..depth-1, inputs blocked
// S_DONE  | one-cycle done pulse, then back to S_RUN
module sfu_acc_bank #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 16,
  parameter int aw      = $clog2(depth),
  parameter int acc_bw  = psum_bw + 4,
  parameter int out_bw  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [1:0]              act_sel,
  input  logic [3:0]              leak_shift,
  input  logic [3:0]              out_shift,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [aw-1:0]           in_addr,
  input  logic                    in_first,
  input  logic [psum_bw*col-1:0]  psum_in,
  input  logic                    flush_start,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [aw-1:0]           out_addr,
  output logic [out_bw*col-1:0]   sfp_out,
  output logic                    busy,
  output logic                    done
);

  localparam int ew = ((acc_bw > out_bw) ? acc_bw : out_bw) + 1;
  localparam int bw = (psum_bw > out_bw) ? psum_bw : out_bw;
  localparam logic [aw-1:0] last_addr = aw'(depth - 1);
  localparam logic signed [ew-1:0] omax = {{(ew-out_bw+1){1'b0}}, {(out_bw-1){1'b1}}};
  localparam logic signed [ew-1:0] omin = {{(ew-out_bw+1){1'b1}}, {(out_bw-1){1'b0}}};

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

  state_t state, state_nxt;
  logic   flush_req;
  logic   flush_go;
  logic   flush_any;
  logic   out_fire;
  logic   out_free;
  logic   in_fire;
  logic [aw-1:0] rd_idx;

  logic signed [acc_bw-1:0] acc     [depth][col];
  logic signed [acc_bw-1:0] acc_nxt [col];
  logic [out_bw*col-1:0]    flush_data;
  logic [out_bw*col-1:0]    bypass_data;

  function automatic logic signed [acc_bw-1:0] sat_acc(input logic signed [acc_bw:0] s);
    if (s[acc_bw] != s[acc_bw-1])
      sat_acc = s[acc_bw] ? {1'b1, {(acc_bw-1){1'b0}}} : {1'b0, {(acc_bw-1){1'b1}}};
    else
      sat_acc = s[acc_bw-1:0];
  endfunction

  function automatic logic [out_bw-1:0] post_proc(input logic signed [acc_bw-1:0] v,
                                                  input logic [1:0] sel,
                                                  input logic [3:0] ls,
                                                  input logic [3:0] os);
    logic signed [acc_bw-1:0] a;
    logic signed [acc_bw-1:0] r;
    logic signed [ew-1:0]     re;
    case (sel)
      2'b01:   a = v[acc_bw-1] ? '0 : v;
      2'b10:   a = v[acc_bw-1] ? (v >>> ls) : v;
      default: a = v;
    endcase
    r  = a >>> os;
    re = {{(ew-acc_bw){r[acc_bw-1]}}, r};
    if (re > omax)      post_proc = omax[out_bw-1:0];
    else if (re < omin) post_proc = omin[out_bw-1:0];
    else                post_proc = re[out_bw-1:0];
  endfunction

  function automatic logic [out_bw-1:0] fit_out(input logic signed [psum_bw-1:0] p);
    logic signed [bw-1:0] t;
    t = bw'(p);
    fit_out = t[out_bw-1:0];
  endfunction

  assign flush_any = flush_start | flush_req;
  assign out_fire  = out_valid & out_ready;
  assign out_free  = ~out_valid | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign busy      = (state == S_FLUSH);
  assign done      = (state == S_DONE);

  // A flush request waits for any pending bypass beat to be taken before it
  // starts presenting entry 0; inputs stay blocked while it waits.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    flush_go  = 1'b0;
    case (state)
      S_RUN: begin
        if (flush_any) begin
          if (out_free) begin
            state_nxt = S_FLUSH;
            flush_go  = 1'b1;
          end
        end else begin
          in_ready = mode ? 1'b1 : out_free;
        end
      end
      S_FLUSH: if (out_fire && (out_addr == last_addr)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // Entry loaded into the output register next: 0 when a flush starts,
  // otherwise the one after the entry currently being accepted.
  assign rd_idx = flush_go ? '0 : out_addr + 1'b1;

  always_comb begin
    logic signed [acc_bw:0] s_old;
    logic signed [acc_bw:0] s_add;
    logic [psum_bw-1:0]     lane;
    flush_data  = '0;
    bypass_data = '0;
    for (int i = 0; i < col; i++) begin
      lane = psum_in[psum_bw*i +: psum_bw];
      flush_data[out_bw*(col-1-i) +: out_bw]  = post_proc(acc[rd_idx][i], act_sel, leak_shift, out_shift);
      bypass_data[out_bw*(col-1-i) +: out_bw] = fit_out(lane);
      s_old = in_first ? '0 : {acc[in_addr][i][acc_bw-1], acc[in_addr][i]};
      s_add = {{(acc_bw+1-psum_bw){lane[psum_bw-1]}}, lane};
      acc_nxt[i] = sat_acc(s_old + s_add);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_RUN;
      flush_req <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      sfp_out   <= '0;
      for (int k = 0; k < depth; k++)
        for (int i = 0; i < col; i++)
          acc[k][i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_RUN: begin
          flush_req <= flush_any & ~flush_go;
          if (flush_go) begin
            out_valid <= 1'b1;
            out_addr  <= '0;
            sfp_out   <= flush_data;
          end else if (in_fire && !mode) begin
            out_valid <= 1'b1;
            out_addr  <= '0;
            sfp_out   <= bypass_data;
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
          if (in_fire && mode)
            for (int i = 0; i < col; i++)
              acc[in_addr][i] <= acc_nxt[i];
        end
        S_FLUSH: begin
          if (out_fire) begin
            for (int i = 0; i < col; i++)
              acc[out_addr][i] <= '0;
            if (out_addr == last_addr) begin
              out_valid <= 1'b0;
              out_addr  <= '0;
            end else begin
              out_addr <= out_addr + 1'b1;
              sfp_out  <= flush_data;
            end
          end
        end
        default: flush_req <= 1'b0;
      endcase
    end
  end

endmodule
